// File: rtl/cr_clint_tcipif_arb.sv
// Core/debug arbiter and single-outstanding sequencer for the CLINT TCIPIF slave port.
// Optional feature macro: CLINT_ARB_LOCK_EN (lock flag pins arbitration to one owner for atomic pair access).
module cr_clint_tcipif_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clint_clk,
  input  logic              cpurst_b,
  input  logic              core_clint_req,
  input  logic              core_clint_write,
  input  logic [ADDR_W-1:0] core_clint_addr,
  input  logic [DATA_W-1:0] core_clint_wdata,
  input  logic              core_clint_lock,
  output logic              clint_core_ack,
  output logic [DATA_W-1:0] clint_core_rdata,
  input  logic              dbg_clint_req,
  input  logic              dbg_clint_write,
  input  logic [ADDR_W-1:0] dbg_clint_addr,
  input  logic [DATA_W-1:0] dbg_clint_wdata,
  input  logic              dbg_clint_lock,
  output logic              clint_dbg_ack,
  output logic [DATA_W-1:0] clint_dbg_rdata,
  output logic              tcipif_clint_sel,
  output logic              tcipif_clint_write,
  output logic [ADDR_W-1:0] tcipif_clint_addr,
  output logic [DATA_W-1:0] tcipif_clint_wdata,
  input  logic              clint_tcipif_cmplt,
  input  logic [DATA_W-1:0] clint_tcipif_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   win_dbg_r;
  logic   ptr_dbg_r;
  logic   core_elig_s;
  logic   dbg_elig_s;
  logic   any_req_s;
  logic   grant_dbg_s;
  logic   lock_hold_s;

`ifdef CLINT_ARB_LOCK_EN
  logic lock_flag_r;
  logic lock_owner_dbg_r;
  logic lat_lock_r;
  logic lock_in_s;

  // While locked only the owner is eligible and the priority pointer stays frozen
  assign core_elig_s = core_clint_req & (~lock_flag_r | ~lock_owner_dbg_r);
  assign dbg_elig_s  = dbg_clint_req & (~lock_flag_r | lock_owner_dbg_r);
  assign lock_in_s   = grant_dbg_s ? dbg_clint_lock : core_clint_lock;
  assign lock_hold_s = lock_flag_r;

  // Lock flag: set by a locked grant, released when the owner completes an unlocked access
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      lock_flag_r      <= 1'b0;
      lock_owner_dbg_r <= 1'b0;
      lat_lock_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            lat_lock_r <= lock_in_s;
            if (lock_in_s) begin
              lock_flag_r      <= 1'b1;
              lock_owner_dbg_r <= grant_dbg_s;
            end
          end
        end
        ST_RESP: begin
          if (lock_flag_r && !lat_lock_r) begin
            lock_flag_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end
`else
  logic unused_lock_s;

  assign unused_lock_s = core_clint_lock ^ dbg_clint_lock;
  assign core_elig_s   = core_clint_req;
  assign dbg_elig_s    = dbg_clint_req;
  assign lock_hold_s   = 1'b0;
`endif

  assign any_req_s   = core_elig_s | dbg_elig_s;
  assign grant_dbg_s = dbg_elig_s & (~core_elig_s | ptr_dbg_r);

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) state_nxt_s = ST_ISSUE;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (clint_tcipif_cmplt) state_nxt_s = ST_RESP;
        else                    state_nxt_s = ST_ISSUE;
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, request latch, bus outputs and per-requester responses
  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_r            <= ST_IDLE;
      win_dbg_r          <= 1'b0;
      ptr_dbg_r          <= 1'b0;
      tcipif_clint_sel   <= 1'b0;
      tcipif_clint_write <= 1'b0;
      tcipif_clint_addr  <= {ADDR_W{1'b0}};
      tcipif_clint_wdata <= {DATA_W{1'b0}};
      clint_core_ack     <= 1'b0;
      clint_dbg_ack      <= 1'b0;
      clint_core_rdata   <= {DATA_W{1'b0}};
      clint_dbg_rdata    <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            win_dbg_r          <= grant_dbg_s;
            tcipif_clint_sel   <= 1'b1;
            tcipif_clint_write <= grant_dbg_s ? dbg_clint_write : core_clint_write;
            tcipif_clint_addr  <= grant_dbg_s ? dbg_clint_addr  : core_clint_addr;
            tcipif_clint_wdata <= grant_dbg_s ? dbg_clint_wdata : core_clint_wdata;
          end
        end
        ST_ISSUE: begin
          // The response registers double as the read-data holding register
          if (clint_tcipif_cmplt) begin
            tcipif_clint_sel <= 1'b0;
            clint_core_ack   <= ~win_dbg_r;
            clint_dbg_ack    <= win_dbg_r;
            clint_core_rdata <= win_dbg_r ? {DATA_W{1'b0}} : clint_tcipif_rdata;
            clint_dbg_rdata  <= win_dbg_r ? clint_tcipif_rdata : {DATA_W{1'b0}};
          end
        end
        ST_RESP: begin
          clint_core_ack   <= 1'b0;
          clint_dbg_ack    <= 1'b0;
          clint_core_rdata <= {DATA_W{1'b0}};
          clint_dbg_rdata  <= {DATA_W{1'b0}};
          if (!lock_hold_s) begin
            ptr_dbg_r <= ~win_dbg_r;
          end
        end
        default: begin
          tcipif_clint_sel <= 1'b0;
          clint_core_ack   <= 1'b0;
          clint_dbg_ack    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_clint_tcipif_arb.sv
// Self-checking bench for cr_clint_tcipif_arb: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and slave stalls.
`timescale 1ns/1ps
module tb_cr_clint_tcipif_arb;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        core_clint_req, core_clint_write, core_clint_lock;
  logic [15:0] core_clint_addr;
  logic [31:0] core_clint_wdata;
  logic        dbg_clint_req, dbg_clint_write, dbg_clint_lock;
  logic [15:0] dbg_clint_addr;
  logic [31:0] dbg_clint_wdata;
  logic        clint_core_ack, clint_dbg_ack;
  logic [31:0] clint_core_rdata, clint_dbg_rdata;
  logic        tcipif_clint_sel, tcipif_clint_write;
  logic [15:0] tcipif_clint_addr;
  logic [31:0] tcipif_clint_wdata;
  logic        clint_tcipif_cmplt;
  logic [31:0] clint_tcipif_rdata;

  always #5 clk = ~clk;

  cr_clint_tcipif_arb #(.ADDR_W(16), .DATA_W(32)) dut (
    .clint_clk(clk), .cpurst_b(cpurst_b),
    .core_clint_req(core_clint_req), .core_clint_write(core_clint_write),
    .core_clint_addr(core_clint_addr), .core_clint_wdata(core_clint_wdata),
    .core_clint_lock(core_clint_lock),
    .clint_core_ack(clint_core_ack), .clint_core_rdata(clint_core_rdata),
    .dbg_clint_req(dbg_clint_req), .dbg_clint_write(dbg_clint_write),
    .dbg_clint_addr(dbg_clint_addr), .dbg_clint_wdata(dbg_clint_wdata),
    .dbg_clint_lock(dbg_clint_lock),
    .clint_dbg_ack(clint_dbg_ack), .clint_dbg_rdata(clint_dbg_rdata),
    .tcipif_clint_sel(tcipif_clint_sel), .tcipif_clint_write(tcipif_clint_write),
    .tcipif_clint_addr(tcipif_clint_addr), .tcipif_clint_wdata(tcipif_clint_wdata),
    .clint_tcipif_cmplt(clint_tcipif_cmplt), .clint_tcipif_rdata(clint_tcipif_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction record plus arbitration bookkeeping
  logic        m_busy, m_resp, m_who_dbg, m_first_dbg, m_write;
  logic        m_lock_flag, m_owner_dbg, m_lat_lock;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_held;
  int          grant_log[$];
  logic [15:0] sel_addr_q[$];
  logic        prev_sel = 1'b0;

  int          stall_fixed = 0;
  int          stall_left = 0;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_resp = 1'b0; m_who_dbg = 1'b0; m_first_dbg = 1'b0;
    m_write = 1'b0; m_addr = 16'h0; m_wdata = 32'h0; m_held = 32'h0;
    m_lock_flag = 1'b0; m_owner_dbg = 1'b0; m_lat_lock = 1'b0;
  endtask

  task automatic model_step();
    logic c, d;
    if (!cpurst_b) begin
      model_reset();
    end else if (m_resp) begin
      m_resp = 1'b0;
      m_busy = 1'b0;
      if (!m_lock_flag) m_first_dbg = !m_who_dbg;
      else if (!m_lat_lock) m_lock_flag = 1'b0;
    end else if (m_busy) begin
      if (clint_tcipif_cmplt) begin
        m_resp = 1'b1;
        m_held = clint_tcipif_rdata;
      end
    end else begin
      c = core_clint_req && (!m_lock_flag || !m_owner_dbg);
      d = dbg_clint_req && (!m_lock_flag || m_owner_dbg);
      if (c || d) begin
        m_who_dbg = (c && d) ? m_first_dbg : d;
        m_busy    = 1'b1;
        m_write   = m_who_dbg ? dbg_clint_write : core_clint_write;
        m_addr    = m_who_dbg ? dbg_clint_addr  : core_clint_addr;
        m_wdata   = m_who_dbg ? dbg_clint_wdata : core_clint_wdata;
`ifdef CLINT_ARB_LOCK_EN
        m_lat_lock = m_who_dbg ? dbg_clint_lock : core_clint_lock;
        if (m_lat_lock) begin
          m_lock_flag = 1'b1;
          m_owner_dbg = m_who_dbg;
        end
`else
        m_lat_lock = 1'b0;
`endif
        grant_log.push_back(int'(m_who_dbg));
      end
    end
  endtask

  task automatic compare();
    logic exp_sel, exp_cack, exp_dack;
    exp_sel  = m_busy && !m_resp;
    exp_cack = m_resp && !m_who_dbg;
    exp_dack = m_resp && m_who_dbg;
    chk("sel", 64'(tcipif_clint_sel), 64'(exp_sel));
    if (exp_sel) begin
      chk("bus_write", 64'(tcipif_clint_write), 64'(m_write));
      chk("bus_addr", 64'(tcipif_clint_addr), 64'(m_addr));
      chk("bus_wdata", 64'(tcipif_clint_wdata), 64'(m_wdata));
    end
    chk("core_ack", 64'(clint_core_ack), 64'(exp_cack));
    chk("dbg_ack", 64'(clint_dbg_ack), 64'(exp_dack));
    chk("core_rdata", 64'(clint_core_rdata), 64'(exp_cack ? m_held : 32'h0));
    chk("dbg_rdata", 64'(clint_dbg_rdata), 64'(exp_dack ? m_held : 32'h0));
  endtask

  task automatic slave_drive();
    if (tcipif_clint_sel) begin
      if (stall_left == 0) begin
        clint_tcipif_cmplt = 1'b1;
        clint_tcipif_rdata = rd_fixed_en ? rd_fixed : $urandom;
      end else begin
        clint_tcipif_cmplt = 1'b0;
        clint_tcipif_rdata = $urandom;
        stall_left--;
      end
    end else begin
      clint_tcipif_cmplt = 1'b0;
      clint_tcipif_rdata = $urandom;
      stall_left = (stall_fixed < 0) ? int'($urandom_range(0, 3)) : stall_fixed;
    end
  endtask

  task automatic set_stall(input int n);
    stall_fixed = n;
    stall_left  = (n < 0) ? 0 : n;
  endtask

  // One clock: model advances on the edge, DUT is compared 1ns later, then the slave responds
  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    compare();
    if (tcipif_clint_sel && !prev_sel) sel_addr_q.push_back(tcipif_clint_addr);
    prev_sel = tcipif_clint_sel;
    slave_drive();
  endtask

  task automatic do_reset();
    cpurst_b = 1'b0;
    cycle();
    cycle();
    cpurst_b = 1'b1;
  endtask

  task automatic rand_req(input logic acked, inout logic req, inout logic wr,
                          inout logic [15:0] a, inout logic [31:0] d, inout logic lk);
    if (acked) begin
      req = 1'($urandom);
    end else if (req) begin
      if ($urandom_range(0, 99) == 0) req = 1'b0;
      else if ($urandom_range(0, 4) == 0) begin
        a = 16'($urandom); d = $urandom; wr = 1'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      req = 1'b1; a = 16'($urandom); d = $urandom; wr = 1'($urandom);
      lk = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    int          sel_cnt, cmplt_cyc, ack_cyc, core_acks;
    logic        got;
    int          exp_g[4]      = '{0, 1, 0, 1};
    logic [15:0] exp_a2[4]     = '{16'h0000, 16'h4000, 16'h0000, 16'h4000};
`ifdef CLINT_ARB_LOCK_EN
    logic [15:0] exp_a5[3]     = '{16'hbff8, 16'hbffc, 16'h0004};
`else
    logic [15:0] exp_a5[3]     = '{16'hbff8, 16'h0004, 16'hbffc};
`endif

    cpurst_b = 1'b0;
    core_clint_req = 1'b0; core_clint_write = 1'b0; core_clint_addr = 16'h0;
    core_clint_wdata = 32'h0; core_clint_lock = 1'b0;
    dbg_clint_req = 1'b0; dbg_clint_write = 1'b0; dbg_clint_addr = 16'h0;
    dbg_clint_wdata = 32'h0; dbg_clint_lock = 1'b0;
    clint_tcipif_cmplt = 1'b0; clint_tcipif_rdata = 32'h0;
    model_reset();
    repeat (3) cycle();
    chk("rst_sel", 64'(tcipif_clint_sel), 64'(1'b0));
    chk("rst_write", 64'(tcipif_clint_write), 64'(1'b0));
    chk("rst_addr", 64'(tcipif_clint_addr), 64'(16'h0));
    chk("rst_wdata", 64'(tcipif_clint_wdata), 64'(32'h0));
    chk("rst_acks", 64'({clint_core_ack, clint_dbg_ack}), 64'(2'b00));
    chk("rst_rdata", 64'({clint_core_rdata, clint_dbg_rdata}), 64'h0);
    cpurst_b = 1'b1;
    cycle();

    // Single core read, slave completes in the same cycle as sel
    rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678; set_stall(0);
    core_clint_req = 1'b1; core_clint_write = 1'b0; core_clint_addr = 16'hbff8;
    cycle();
    chk("t1_sel", 64'(tcipif_clint_sel), 64'(1'b1));
    chk("t1_addr", 64'(tcipif_clint_addr), 64'(16'hbff8));
    cycle();
    chk("t1_core_ack", 64'(clint_core_ack), 64'(1'b1));
    chk("t1_core_rdata", 64'(clint_core_rdata), 64'(32'h1234_5678));
    chk("t1_dbg_ack", 64'(clint_dbg_ack), 64'(1'b0));
    core_clint_req = 1'b0;
    cycle();
    chk("t1_ack_pulse", 64'(clint_core_ack), 64'(1'b0));

    // Continuous contention from reset: core first, then strict alternation
    do_reset();
    grant_log.delete(); sel_addr_q.delete(); rd_fixed_en = 1'b0;
    core_clint_req = 1'b1; core_clint_addr = 16'h0000;
    dbg_clint_req = 1'b1; dbg_clint_write = 1'b0; dbg_clint_addr = 16'h4000;
    repeat (12) cycle();
    core_clint_req = 1'b0; dbg_clint_req = 1'b0;
    repeat (3) cycle();
    chk("t2_grant_count", 64'(grant_log.size()), 64'(4));
    chk("t2_sel_count", 64'(sel_addr_q.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant_order", (i < grant_log.size()) ? 64'(grant_log[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_g[i]));
      chk("t2_sel_addr", (i < sel_addr_q.size()) ? 64'(sel_addr_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_a2[i]));
    end

    // Debug write with a 3-cycle stalled completion
    set_stall(3);
    dbg_clint_req = 1'b1; dbg_clint_write = 1'b1; dbg_clint_addr = 16'h4000; dbg_clint_wdata = 32'hA5A5_0001;
    sel_cnt = 0; cmplt_cyc = -1; ack_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (tcipif_clint_sel) begin
        sel_cnt++;
        chk("t3_write", 64'(tcipif_clint_write), 64'(1'b1));
        chk("t3_wdata", 64'(tcipif_clint_wdata), 64'(32'hA5A5_0001));
      end
      if (clint_dbg_ack) begin
        ack_cyc = cyc;
        dbg_clint_req = 1'b0;
      end
      if (clint_tcipif_cmplt) cmplt_cyc = cyc;
    end
    chk("t3_sel_cycles", 64'(sel_cnt), 64'(4));
    chk("t3_ack_after_cmplt", 64'(ack_cyc), 64'(cmplt_cyc + 1));

    // Reset while the access is in ISSUE
    set_stall(10); rd_fixed_en = 1'b1; rd_fixed = 32'hCAFE_0004;
    core_clint_req = 1'b1; core_clint_write = 1'b0; core_clint_addr = 16'hbff8;
    cycle();
    chk("t4_sel_before", 64'(tcipif_clint_sel), 64'(1'b1));
    cpurst_b = 1'b0;
    #1;
    chk("t4_sel_in_rst", 64'(tcipif_clint_sel), 64'(1'b0));
    chk("t4_ack_in_rst", 64'(clint_core_ack), 64'(1'b0));
    set_stall(0);
    cycle();
    cycle();
    cpurst_b = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (clint_core_ack) begin
        got = 1'b1;
        chk("t4_rdata", 64'(clint_core_rdata), 64'(32'hCAFE_0004));
      end
    end
    chk("t4_served", 64'(got), 64'(1'b1));
    core_clint_req = 1'b0;
    cycle();

    // Locked pair from core while debug keeps requesting
    do_reset();
    sel_addr_q.delete(); rd_fixed_en = 1'b0; core_acks = 0;
    core_clint_req = 1'b1; core_clint_lock = 1'b1; core_clint_addr = 16'hbff8;
    dbg_clint_req = 1'b1; dbg_clint_lock = 1'b0; dbg_clint_write = 1'b0; dbg_clint_addr = 16'h0004;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (m_resp && !m_who_dbg) begin
        core_acks++;
        if (core_acks == 1) begin
          core_clint_lock = 1'b0; core_clint_addr = 16'hbffc;
        end else begin
          core_clint_req = 1'b0;
        end
      end
      if (m_resp && m_who_dbg) dbg_clint_req = 1'b0;
    end
    chk("t5_sel_count", 64'(sel_addr_q.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      chk("t5_sel_addr", (i < sel_addr_q.size()) ? 64'(sel_addr_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_a5[i]));
    end
    core_clint_req = 1'b0; dbg_clint_req = 1'b0; core_clint_lock = 1'b0;

    // Randomized traffic with random stalls, field churn, early drops and one mid-run reset
    do_reset();
    set_stall(-1);
    for (int i = 0; i < 3000; i++) begin
      cycle();
      rand_req(m_resp && !m_who_dbg, core_clint_req, core_clint_write, core_clint_addr,
               core_clint_wdata, core_clint_lock);
      rand_req(m_resp && m_who_dbg, dbg_clint_req, dbg_clint_write, dbg_clint_addr,
               dbg_clint_wdata, dbg_clint_lock);
      if (i == 1500) cpurst_b = 1'b0;
      if (i == 1502) cpurst_b = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
